// File: rtl/keypad_row_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_row_scanner_if
// Brief    : Key-report handshake between the row scanner and its consumer.
//            The scanner drives valid/code; the consumer returns ready.
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_row_scanner_if #(
  parameter int COLS = 4
);
  localparam int KW = 3 + $clog2(COLS);

  logic          key_valid;
  logic [KW-1:0] key_code;
  logic          key_ready;

  modport master (
    output key_valid,
    output key_code,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    output key_ready
  );
endinterface
`default_nettype wire

// File: rtl/keypad_row_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_row_scanner
// Brief    : Steps a 3-bit row index over rows 0..7, lets each row settle,
//            samples the columns and reports at most one newly pressed key
//            per row per frame over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_row_scanner #(
  parameter int SETTLE_CYC = 4,
  parameter int COLS       = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 en,
  input  wire logic [COLS-1:0]      col_in,
  output logic      [2:0]           row_sel,
  output logic                      row_en,
  output logic                      scan_done,
  keypad_row_scanner_if.master      key_if
);

  localparam int KW    = 3 + $clog2(COLS);
  localparam int CBITS = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNTW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [CNTW-1:0]   cnt, cnt_next;
  logic [2:0]        row_sel_next;
  logic              row_en_next;
  logic              done_next;
  logic              valid_reg, valid_next;
  logic [KW-1:0]     code_reg, code_next;
  logic              advance;

  // Held-key mask, one COLS-wide entry per row
  logic [COLS-1:0]   mask [8];
  logic              mask_we;
  logic [COLS-1:0]   mask_wdata;

  logic [COLS-1:0]   new_keys;
  logic [CBITS-1:0]  low_idx;
  logic [COLS-1:0]   low_onehot;
  logic [KW-1:0]     code_w;

  assign key_if.key_valid = valid_reg;
  assign key_if.key_code  = code_reg;

  // Keys pressed now that were not already held on this row at the last sample
  assign new_keys   = col_in & ~mask[row_sel];
  assign low_onehot = COLS'(1) << low_idx;

  // Priority pick of the lowest-numbered newly pressed column
  always_comb begin
    low_idx = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (new_keys[i]) begin
        low_idx = CBITS'(i);
      end
    end
  end

  // Report code is {row, column}; a single-column keypad reports the row only
  generate
    if (COLS > 1) begin : g_code_rowcol
      assign code_w = {row_sel, low_idx};
    end else begin : g_code_row
      assign code_w = row_sel;
    end
  endgenerate

  // Next-state and next-output logic; row advance is shared by SAMPLE and HOLD
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    row_sel_next = row_sel;
    row_en_next  = row_en;
    done_next    = 1'b0;
    valid_next   = valid_reg;
    code_next    = code_reg;
    mask_we      = 1'b0;
    mask_wdata   = mask[row_sel];
    advance      = 1'b0;

    case (state)
      IDLE: begin
        row_en_next  = 1'b0;
        row_sel_next = 3'd0;
        if (en) begin
          state_next  = SETTLE;
          row_en_next = 1'b1;
          cnt_next    = '0;
        end
      end
      SETTLE: begin
        if (cnt == CNT_LAST) begin
          state_next = SAMPLE;
        end else begin
          cnt_next = cnt + CNTW'(1);
        end
      end
      SAMPLE: begin
        mask_we = 1'b1;
        if (|new_keys) begin
          // Reported key joins the mask; other new keys wait for later frames
          mask_wdata = (mask[row_sel] & col_in) | low_onehot;
          code_next  = code_w;
          valid_next = 1'b1;
          state_next = HOLD;
        end else begin
          mask_wdata = mask[row_sel] & col_in;
          advance    = 1'b1;
        end
      end
      HOLD: begin
        if (key_if.key_ready) begin
          valid_next = 1'b0;
          advance    = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (advance) begin
      row_sel_next = row_sel + 3'd1;
      done_next    = (row_sel == 3'd7);
      if (en) begin
        state_next = SETTLE;
        cnt_next   = '0;
      end else begin
        state_next   = IDLE;
        row_en_next  = 1'b0;
        row_sel_next = 3'd0;
      end
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      row_sel   <= 3'd0;
      row_en    <= 1'b0;
      scan_done <= 1'b0;
      valid_reg <= 1'b0;
      code_reg  <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      row_sel   <= row_sel_next;
      row_en    <= row_en_next;
      scan_done <= done_next;
      valid_reg <= valid_next;
      code_reg  <= code_next;
    end
  end

  // Held-key mask update on the sampled row
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 8; r++) begin
        mask[r] <= '0;
      end
    end else if (mask_we) begin
      mask[row_sel] <= mask_wdata;
    end
  end

endmodule
`default_nettype wire
